// File: rtl/irq_controller.sv
// irq_controller: collects N_SRC rising-edge interrupt sources into pending
// bits, masks them with per-source enables, arbitrates one winner and runs an
// ack/done handshake with the core so that at most one interrupt is in service.
// Configuration macro: IRQ_RR_EN selects round-robin arbitration; when it is
// undefined, fixed priority (lowest index wins) is used and no pointer exists.
module irq_controller #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_en,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             interrupt,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_active,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             interrupt_q, irq_active_q;

  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] req_vec_s;
  logic [N_SRC-1:0] clr_mask_s;
  logic             win_vld_s;
  logic [ID_W-1:0]  win_id_s;
  logic             ack_take_s;

  // A source line high now but low last cycle is a new request; src_q resets
  // to 0 so a line already high at reset release counts as an edge.
  assign rise_s    = irq_src & ~src_q;
  // Enables only gate arbitration; pending bits themselves are never masked.
  assign req_vec_s = pending_q & irq_en;
  assign win_vld_s = |req_vec_s;

`ifdef IRQ_RR_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            hi_vld_s;
  logic [ID_W-1:0] hi_id_s;
  logic [ID_W-1:0] lo_id_s;

  // Round-robin winner: lowest requester above rr_ptr, else wrap to the lowest.
  always_comb begin
    hi_vld_s = 1'b0;
    hi_id_s  = {ID_W{1'b0}};
    lo_id_s  = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      lo_id_s  = req_vec_s[i] ? ID_W'(i) : lo_id_s;
      hi_id_s  = (req_vec_s[i] && (ID_W'(i) > rr_ptr_q)) ? ID_W'(i) : hi_id_s;
      hi_vld_s = hi_vld_s | (req_vec_s[i] && (ID_W'(i) > rr_ptr_q));
    end
    win_id_s = hi_vld_s ? hi_id_s : lo_id_s;
  end

  // Only an accepted ack advances the pointer; withdrawn requests leave it.
  assign rr_ptr_d = ack_take_s ? irq_id_q : rr_ptr_q;

  // Round-robin pointer register; starts at the top so source 0 goes first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= ID_W'(N_SRC - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority winner: scanning downward leaves the lowest requester.
  always_comb begin
    win_id_s = {ID_W{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      win_id_s = req_vec_s[i] ? ID_W'(i) : win_id_s;
    end
  end
`endif

  // Handshake FSM next state; irq_id is captured only when leaving IDLE.
  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    ack_take_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld_s) begin
          state_d  = REQ;
          irq_id_d = win_id_s;
        end else begin
          state_d  = IDLE;
        end
      end
      REQ: begin
        // Ack has precedence over both a simultaneous done and a mask drop.
        if (irq_ack) begin
          ack_take_s = 1'b1;
          state_d    = SERVICE;
        end else if (!irq_en[irq_id_q]) begin
          state_d    = IDLE;
        end else begin
          state_d    = REQ;
        end
      end
      SERVICE: begin
        if (irq_done) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ack clears the served bit, but a fresh edge on the same cycle re-sets it.
  assign clr_mask_s = ack_take_s ? ({{(N_SRC - 1){1'b0}}, 1'b1} << irq_id_q)
                                 : {N_SRC{1'b0}};
  assign pending_d  = (pending_q & ~clr_mask_s) | rise_s;

  // Source history and pending bit registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q     <= {N_SRC{1'b0}};
      pending_q <= {N_SRC{1'b0}};
    end else begin
      src_q     <= irq_src;
      pending_q <= pending_d;
    end
  end

  // FSM state, held irq_id and registered state-decoded outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      irq_id_q     <= {ID_W{1'b0}};
      interrupt_q  <= 1'b0;
      irq_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_id_q     <= irq_id_d;
      interrupt_q  <= (state_d == REQ);
      irq_active_q <= (state_d == SERVICE);
    end
  end

  assign interrupt  = interrupt_q;
  assign irq_id     = irq_id_q;
  assign irq_active = irq_active_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller (N_SRC = 4): a table of single-cycle
// vectors for the main flow plus hand-written multi-cycle sequences.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] irq_src = 4'b0000;
  logic [3:0] irq_en = 4'b1111;
  logic       irq_ack = 1'b0;
  logic       irq_done = 1'b0;
  logic       interrupt;
  logic [1:0] irq_id;
  logic       irq_active;
  logic [3:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  irq_controller #(.N_SRC(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_src    (irq_src),
    .irq_en     (irq_en),
    .irq_ack    (irq_ack),
    .irq_done   (irq_done),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .irq_active (irq_active),
    .pending    (pending)
  );

  always #5 clk = ~clk;

`ifdef IRQ_RR_EN
  // Pointer is 2 after the first served source 2, so source 3 is searched first.
  localparam logic [1:0] ID_FIRST  = 2'd3;
  localparam logic [1:0] ID_SECOND = 2'd1;
  localparam logic [3:0] PEND_MID  = 4'b0010;
  localparam logic [1:0] RR_EXP0 = 2'd0, RR_EXP1 = 2'd1, RR_EXP2 = 2'd0, RR_EXP3 = 2'd1;
`else
  localparam logic [1:0] ID_FIRST  = 2'd1;
  localparam logic [1:0] ID_SECOND = 2'd3;
  localparam logic [3:0] PEND_MID  = 4'b1000;
  localparam logic [1:0] RR_EXP0 = 2'd0, RR_EXP1 = 2'd0, RR_EXP2 = 2'd0, RR_EXP3 = 2'd0;
`endif

  typedef struct {
    logic [3:0] src;
    logic [3:0] en;
    logic       ack;
    logic       done;
    logic       e_int;
    logic [1:0] e_id;
    logic       e_act;
    logic [3:0] e_pend;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl [NV];

  // Drive inputs on the falling edge, then move to just after the rising edge.
  task automatic step(input logic [3:0] src, input logic [3:0] en,
                      input logic ack, input logic done);
    @(negedge clk);
    irq_src  = src;
    irq_en   = en;
    irq_ack  = ack;
    irq_done = done;
    @(posedge clk);
    #1;
  endtask

  // irq_id is only compared where it is defined (REQ or SERVICE).
  task automatic check(input string nm, input logic e_int, input logic [1:0] e_id,
                       input logic e_act, input logic [3:0] e_pend);
    n_cmp++;
    if (interrupt !== e_int || irq_active !== e_act || pending !== e_pend ||
        ((e_int || e_act) && irq_id !== e_id)) begin
      n_err++;
      $display("FAIL %s: got int=%b id=%0d act=%b pend=%b, want int=%b id=%0d act=%b pend=%b",
               nm, interrupt, irq_id, irq_active, pending, e_int, e_id, e_act, e_pend);
    end
  endtask

  task automatic check_id(input string nm, input logic [1:0] e_id);
    n_cmp++;
    if (irq_id !== e_id) begin
      n_err++;
      $display("FAIL %s: got irq_id=%0d, want %0d", nm, irq_id, e_id);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [4];
    logic [1:0] e;
    rr_exp[0] = RR_EXP0; rr_exp[1] = RR_EXP1; rr_exp[2] = RR_EXP2; rr_exp[3] = RR_EXP3;

    //            src      en       ack   done  int   id         act   pend
    tbl[0]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0100};
    tbl[2]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2,      1'b0, 4'b0100};
    tbl[3]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd2,      1'b0, 4'b0100};
    tbl[4]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2,      1'b1, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd2,      1'b1, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[10] = '{4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b1010};
    tbl[11] = '{4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1, ID_FIRST,  1'b0, 4'b1010};
    tbl[12] = '{4'b1010, 4'b1111, 1'b0, 1'b1, 1'b1, ID_FIRST,  1'b0, 4'b1010};
    tbl[13] = '{4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0, ID_FIRST,  1'b1, PEND_MID};
    tbl[14] = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, PEND_MID};
    tbl[15] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, ID_SECOND, 1'b0, PEND_MID};
    tbl[16] = '{4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0, ID_SECOND, 1'b1, 4'b0000};
    tbl[17] = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[18] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0001};
    tbl[19] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0,      1'b0, 4'b0001};
    tbl[20] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0,      1'b0, 4'b0001};
    tbl[21] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0,      1'b0, 4'b0001};
    tbl[22] = '{4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0,      1'b1, 4'b0001};
    tbl[23] = '{4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0001};
    tbl[24] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0,      1'b0, 4'b0001};
    tbl[25] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0,      1'b1, 4'b0000};
    tbl[26] = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0000};
    tbl[27] = '{4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0001};
    tbl[28] = '{4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0001};
    tbl[29] = '{4'b0000, 4'b1110, 1'b0, 1'b0, 1'b0, 2'd0,      1'b0, 4'b0001};
    tbl[30] = '{4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0,      1'b0, 4'b0001};
    tbl[31] = '{4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0,      1'b1, 4'b0000};
    tbl[32] = '{4'b0000, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0,      1'b0, 4'b0000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b0, 2'd0, 1'b0, 4'b0000);
    check_id("reset_id", 2'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Main vector table.
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].src, tbl[i].en, tbl[i].ack, tbl[i].done);
      check($sformatf("vec%0d", i), tbl[i].e_int, tbl[i].e_id, tbl[i].e_act, tbl[i].e_pend);
    end

    // Mask and withdraw while in REQ with irq_id=2.
    step(4'b0100, 4'b1111, 1'b0, 1'b0); check("wd_pend",    1'b0, 2'd0, 1'b0, 4'b0100);
    step(4'b0100, 4'b1111, 1'b0, 1'b0); check("wd_req",     1'b1, 2'd2, 1'b0, 4'b0100);
    step(4'b0100, 4'b1011, 1'b0, 1'b0); check("wd_drop",    1'b0, 2'd0, 1'b0, 4'b0100);
    step(4'b0100, 4'b1011, 1'b0, 1'b0); check("wd_hold",    1'b0, 2'd0, 1'b0, 4'b0100);
    step(4'b0100, 4'b1111, 1'b0, 1'b0); check("wd_reen",    1'b1, 2'd2, 1'b0, 4'b0100);
    step(4'b0000, 4'b1111, 1'b1, 1'b0); check("wd_ack",     1'b0, 2'd2, 1'b1, 4'b0000);
    step(4'b0000, 4'b1111, 1'b0, 1'b1); check("wd_done",    1'b0, 2'd0, 1'b0, 4'b0000);

    // Sources 0 and 1 kept pending by re-pulsing; four interrupts served.
    step(4'b0011, 4'b1111, 1'b0, 1'b0); check("rr_pend", 1'b0, 2'd0, 1'b0, 4'b0011);
    for (int k = 0; k < 4; k++) begin
      e = rr_exp[k];
      step(4'b0011, 4'b1111, 1'b0, 1'b0);
      check($sformatf("rr_req%0d", k), 1'b1, e, 1'b0, 4'b0011);
      step(4'b0000, 4'b1111, 1'b1, 1'b0);
      check($sformatf("rr_ack%0d", k), 1'b0, e, 1'b1, 4'b0011 & ~(4'b0001 << e));
      step(4'b0011, 4'b1111, 1'b0, 1'b1);
      check($sformatf("rr_done%0d", k), 1'b0, 2'd0, 1'b0, 4'b0011);
    end

    // Reset in SERVICE with irq_src[0] held high.
    step(4'b0011, 4'b1111, 1'b0, 1'b0); check("rst_req", 1'b1, 2'd0, 1'b0, 4'b0011);
    step(4'b0011, 4'b1111, 1'b1, 1'b0); check("rst_svc", 1'b0, 2'd0, 1'b1, 4'b0010);
    @(negedge clk);
    irq_ack = 1'b0;
    irq_src = 4'b0001;
    rstn    = 1'b0;
    #1;
    check("rst_async", 1'b0, 2'd0, 1'b0, 4'b0000);
    check_id("rst_async_id", 2'd0);
    @(posedge clk);
    #1;
    check("rst_held", 1'b0, 2'd0, 1'b0, 4'b0000);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge1", 1'b0, 2'd0, 1'b0, 4'b0001);
    @(posedge clk);
    #1;
    check("rst_edge2", 1'b1, 2'd0, 1'b0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
